ledmatrix_btn_debounce: RTL and testbench
=========================================

// Module: ledmatrix_btn_debounce
// PURPOSE
//  Synchronizes and debounces one raw push-button/switch input ahead of the 1-bit
//  Avalon input PIO of the ledMatrix system. btn_level drives the PIO in_port, so
//  software reads a clean level at PIO address 0, bit 0.
//  Also emits 1-cycle press/release pulses for local fabric logic, e.g. the
//  matrix pattern stepper.
// PARAMETERS
//  SYNC_STAGES    2        flops in the input synchronizer chain (>=2)
//  STABLE_CYCLES  1000000  cycles the input must hold before a change is accepted (20 ms @ 50 MHz)
//  CNT_W          20       stability counter width; must hold STABLE_CYCLES-1
//  ACTIVE_LOW     1        1: btn_raw==0 means pressed; 0: btn_raw==1 means pressed
// PORTS
//  clk          in   1  system clock; all logic on the rising edge
//  reset_n      in   1  asynchronous, active-low reset
//  btn_raw      in   1  raw pad input, asynchronous to clk, bouncing
//  btn_level    out  1  debounced level, 1 = pressed; connects to PIO in_port
//  btn_press    out  1  1-cycle pulse when pressed is accepted
//  btn_release  out  1  1-cycle pulse when released is accepted
//  press_flag   out  1  [BTN_STICKY_EN only] sticky press indicator
//  flag_clr     in   1  [BTN_STICKY_EN only] synchronous clear of press_flag
// BEHAVIOUR
//  - Reset, asynchronous:
//    - Synchronizer flops take the released raw level: 1 if ACTIVE_LOW, else 0.
//    - FSM = REL, counter = 0.
//    - btn_level, btn_press, btn_release and press_flag are all 0.
//  - Polarity: btn_raw is XORed with ACTIVE_LOW after the last sync stage, giving
//    p (1 = pressed).
//  - FSM states: REL, CHK_P, PRS, CHK_R. The FSM acts on p on each rising edge:
//    - REL:   p=1 -> CHK_P with cnt=0.
//    - CHK_P: p=0 -> REL with cnt=0 (bounce rejected).
//             p=1 and cnt<STABLE_CYCLES-1 -> cnt++.
//             p=1 and cnt==STABLE_CYCLES-1 -> PRS with cnt=0, btn_level<=1, btn_press<=1.
//    - PRS:   mirrors REL; p=0 -> CHK_R.
//    - CHK_R: mirrors CHK_P; on acceptance -> REL with btn_level<=0, btn_release<=1.
//  - All outputs are registered. btn_press and btn_release are high for exactly
//    one cycle and are never high together.
//  - Latency: let edge 0 be the first clock edge at which sync stage 0 captures a
//    clean transition. btn_level and the pulse change at edge SYNC_STAGES+STABLE_CYCLES.
//  - Glitches: any excursion of p shorter than STABLE_CYCLES cycles leaves
//    btn_level unchanged and produces no pulse. The counter restarts from 0 on
//    every bounce.
//  - Counter never wraps: it saturates by construction, since it is cleared on
//    every state change.
//  - Reset asserted mid-count: the block returns immediately to the reset state
//    and no pulse is emitted for the aborted transition.
//  - After reset deassertion with the button held, the press is accepted after
//    the full latency and btn_press pulses once.
// CONFIGURATION
//  - Macro BTN_STICKY_EN.
//  - Defined: ports press_flag and flag_clr exist.
//    - press_flag is set on the cycle after btn_press=1 and held until flag_clr=1.
//    - flag_clr clears it on the next edge.
//    - If set and clear occur in the same cycle, set wins.
//  - Undefined: neither port exists and no flag register is built. All other
//    behaviour is identical.
// STRUCTURE
//  - Package ledmatrix_pkg holds:
//    - FSM state encoding localparams ST_REL=2'd0, ST_CHK_P=2'd1, ST_PRS=2'd2, ST_CHK_R=2'd3;
//    - default debounce constants.
//  - One sub-module: ledmatrix_sync, a parameterized N-stage synchronizer with a
//    parameterized reset value.
//  - The FSM, counter and output registers stay in the top module.
// TESTING (bench uses SYNC_STAGES=2, STABLE_CYCLES=4, ACTIVE_LOW=1)
//  1. Reset, btn_raw=1 held -> all outputs 0; no pulses for 50 cycles.
//  2. btn_raw 1->0 sampled at edge 0, then held -> btn_level=1 and btn_press=1
//     at edge 6; btn_press=0 at edge 7.
//  3. btn_raw low for 3 cycles then high (bounce) -> btn_level stays 0, no pulse;
//     a following clean low still takes the full 6 edges.
//  4. Pressed state, btn_raw 0->1 held -> btn_release pulses once at edge 6 and
//     btn_level=0; btn_press stays 0 throughout.
//  5. reset_n low at edge 4 of an accepting press -> outputs 0 at once; after
//     release of reset with btn_raw=0, btn_press pulses exactly once.
//  6. BTN_STICKY_EN: press -> press_flag=1 held for 20 cycles; flag_clr=1 in the
//     same cycle as a new btn_press -> press_flag stays 1; lone flag_clr -> 0 next edge.

Source files
------------

// File: rtl/ledmatrix_pkg.sv
// Shared FSM state encoding, default debounce constants and the reset-level helper
// used by the ledMatrix button debouncer.
package ledmatrix_pkg;

  localparam logic [1:0] ST_REL   = 2'd0;
  localparam logic [1:0] ST_CHK_P = 2'd1;
  localparam logic [1:0] ST_PRS   = 2'd2;
  localparam logic [1:0] ST_CHK_R = 2'd3;

  typedef enum logic [1:0] {
    S_REL   = ST_REL,
    S_CHK_P = ST_CHK_P,
    S_PRS   = ST_PRS,
    S_CHK_R = ST_CHK_R
  } btn_state_t;

  // 20 ms at 50 MHz
  localparam int DEF_SYNC_STAGES   = 2;
  localparam int DEF_STABLE_CYCLES = 1000000;
  localparam int DEF_CNT_W         = 20;
  localparam int DEF_ACTIVE_LOW    = 1;

  // Raw pad level seen while the button is released.
  function automatic logic released_level(input int active_low);
    return (active_low != 0);
  endfunction

endpackage

// File: rtl/ledmatrix_sync.sv
// N-stage flop synchronizer with a configurable reset value; latency STAGES cycles,
// no backpressure (free-running, samples every clock).
module ledmatrix_sync #(
  parameter int   STAGES  = 2,
  parameter logic RST_VAL = 1'b0
) (
  input  logic clk,
  input  logic reset_n,
  input  logic d,
  output logic q
);

  logic [STAGES-1:0] chain;

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      chain <= {STAGES{RST_VAL}};
    end else begin
      chain <= {chain[STAGES-2:0], d};
    end
  end

  assign q = chain[STAGES-1];

endmodule

// File: rtl/ledmatrix_btn_debounce.sv
// Push-button synchronizer/debouncer: level and pulses change SYNC_STAGES+STABLE_CYCLES
// edges after a clean input change; no backpressure. BTN_STICKY_EN adds press_flag/flag_clr.
module ledmatrix_btn_debounce
  import ledmatrix_pkg::*;
#(
  parameter int SYNC_STAGES   = DEF_SYNC_STAGES,
  parameter int STABLE_CYCLES = DEF_STABLE_CYCLES,
  parameter int CNT_W         = DEF_CNT_W,
  parameter int ACTIVE_LOW    = DEF_ACTIVE_LOW
) (
  input  logic clk,
  input  logic reset_n,
  input  logic btn_raw,
`ifdef BTN_STICKY_EN
  input  logic flag_clr,
  output logic press_flag,
`endif
  output logic btn_level,
  output logic btn_press,
  output logic btn_release
);

  localparam logic             REL_LVL = released_level(ACTIVE_LOW);
  localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(STABLE_CYCLES - 1);

  logic       raw_sync;
  logic       p;
  btn_state_t state, state_nxt;
  logic [CNT_W-1:0] cnt, cnt_nxt;
  logic       level_nxt;
  logic       press_nxt;
  logic       release_nxt;

  ledmatrix_sync #(
    .STAGES  (SYNC_STAGES),
    .RST_VAL (REL_LVL)
  ) u_sync (
    .clk     (clk),
    .reset_n (reset_n),
    .d       (btn_raw),
    .q       (raw_sync)
  );

  // p is 1 while the (synchronized) button reads as pressed, whatever the pad polarity.
  assign p = raw_sync ^ REL_LVL;

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state       <= S_REL;
      cnt         <= '0;
      btn_level   <= 1'b0;
      btn_press   <= 1'b0;
      btn_release <= 1'b0;
    end else begin
      state       <= state_nxt;
      cnt         <= cnt_nxt;
      btn_level   <= level_nxt;
      btn_press   <= press_nxt;
      btn_release <= release_nxt;
    end
  end

  // Counter is cleared on every state change, so it can never pass CNT_MAX.
  always_comb begin
    state_nxt   = state;
    cnt_nxt     = cnt;
    level_nxt   = btn_level;
    press_nxt   = 1'b0;
    release_nxt = 1'b0;
    case (state)
      S_REL: begin
        if (p) begin
          state_nxt = S_CHK_P;
          cnt_nxt   = '0;
        end
      end
      S_CHK_P: begin
        if (!p) begin
          state_nxt = S_REL;
          cnt_nxt   = '0;
        end else if (cnt == CNT_MAX) begin
          state_nxt = S_PRS;
          cnt_nxt   = '0;
          level_nxt = 1'b1;
          press_nxt = 1'b1;
        end else begin
          cnt_nxt = cnt + CNT_W'(1);
        end
      end
      S_PRS: begin
        if (!p) begin
          state_nxt = S_CHK_R;
          cnt_nxt   = '0;
        end
      end
      S_CHK_R: begin
        if (p) begin
          state_nxt = S_PRS;
          cnt_nxt   = '0;
        end else if (cnt == CNT_MAX) begin
          state_nxt   = S_REL;
          cnt_nxt     = '0;
          level_nxt   = 1'b0;
          release_nxt = 1'b1;
        end else begin
          cnt_nxt = cnt + CNT_W'(1);
        end
      end
      default: begin
        state_nxt = S_REL;
        cnt_nxt   = '0;
      end
    endcase
  end

`ifdef BTN_STICKY_EN
  // A press arriving together with a clear must not be lost, so set has priority.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      press_flag <= 1'b0;
    end else if (btn_press) begin
      press_flag <= 1'b1;
    end else if (flag_clr) begin
      press_flag <= 1'b0;
    end
  end
`endif

endmodule

// File: tb/tb_ledmatrix_btn_debounce.sv
// Directed self-checking bench for ledmatrix_btn_debounce (SYNC_STAGES=2, STABLE_CYCLES=4).
module tb_ledmatrix_btn_debounce;

  logic clk;
  logic reset_n;
  logic btn_raw;
  logic btn_level;
  logic btn_press;
  logic btn_release;
`ifdef BTN_STICKY_EN
  logic press_flag;
  logic flag_clr;
`endif

  int checks   = 0;
  int failures = 0;
  int press_cnt = 0;
  int rel_cnt   = 0;
  int both_cnt  = 0;
  int snap_p;
  int snap_r;

  ledmatrix_btn_debounce #(
    .SYNC_STAGES   (2),
    .STABLE_CYCLES (4),
    .CNT_W         (20),
    .ACTIVE_LOW    (1)
  ) dut (
    .clk         (clk),
    .reset_n     (reset_n),
    .btn_raw     (btn_raw),
`ifdef BTN_STICKY_EN
    .flag_clr    (flag_clr),
    .press_flag  (press_flag),
`endif
    .btn_level   (btn_level),
    .btn_press   (btn_press),
    .btn_release (btn_release)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  always @(negedge clk) begin
    if (btn_press)                press_cnt++;
    if (btn_release)              rel_cnt++;
    if (btn_press && btn_release) both_cnt++;
  end

  task automatic check(input string tag, input int got, input int exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s got=%0d exp=%0d", tag, got, exp);
    end
  endtask

  // Returns just after the n-th rising edge from now.
  task automatic edges(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  // Drive btn_raw at a falling edge; the next rising edge is edge 0.
  task automatic drive(input logic raw);
    @(negedge clk);
    btn_raw = raw;
  endtask

  // Clean transition: level flips and the matching pulse fires exactly at edge 6.
  task automatic clean_change(input string tag, input logic raw, input logic exp_level);
    drive(raw);
    edges(6);
    check({tag, "_lvl_e5"}, btn_level, !exp_level);
    check({tag, "_press_e5"}, btn_press, 0);
    edges(1);
    check({tag, "_lvl_e6"}, btn_level, exp_level);
    check({tag, "_press_e6"}, btn_press, exp_level);
    check({tag, "_rel_e6"}, btn_release, !exp_level);
    edges(1);
    check({tag, "_press_e7"}, btn_press, 0);
    check({tag, "_rel_e7"}, btn_release, 0);
    check({tag, "_lvl_e7"}, btn_level, exp_level);
  endtask

  initial begin
    reset_n = 1'b0;
    btn_raw = 1'b1;
`ifdef BTN_STICKY_EN
    flag_clr = 1'b0;
`endif
    #1;
    check("rst_level", btn_level, 0);
    check("rst_press", btn_press, 0);
    check("rst_release", btn_release, 0);
    edges(3);
    @(negedge clk);
    reset_n = 1'b1;

    // 1: idle released for 50 cycles
    edges(50);
    check("idle_level", btn_level, 0);
    check("idle_press_cnt", press_cnt, 0);
    check("idle_rel_cnt", rel_cnt, 0);
`ifdef BTN_STICKY_EN
    check("idle_flag", press_flag, 0);
`endif

    // 2: clean press
    clean_change("press", 1'b0, 1'b1);
    check("press_once", press_cnt, 1);

    // 4: clean release
    snap_p = press_cnt;
    clean_change("release", 1'b1, 1'b0);
    check("release_once", rel_cnt, 1);
    check("release_no_press", press_cnt, snap_p);

    // 3: 3-cycle low bounce is rejected, then a clean low takes full latency
    drive(1'b0);
    edges(3);
    drive(1'b1);
    edges(12);
    check("bounce_level", btn_level, 0);
    check("bounce_press_cnt", press_cnt, 1);
    clean_change("after_bounce", 1'b0, 1'b1);
    clean_change("release2", 1'b1, 1'b0);

    // 5: reset at edge 4 of an accepting press
    snap_p = press_cnt;
    drive(1'b0);
    repeat (5) @(posedge clk);
    #2;
    reset_n = 1'b0;
    #1;
    check("midrst_level", btn_level, 0);
    check("midrst_press", btn_press, 0);
    edges(3);
    check("midrst_no_pulse", press_cnt, snap_p);
    @(negedge clk);
    reset_n = 1'b1;
    edges(6);
    check("postrst_lvl_e5", btn_level, 0);
    edges(1);
    check("postrst_lvl_e6", btn_level, 1);
    check("postrst_press_e6", btn_press, 1);
    edges(20);
    check("postrst_press_once", press_cnt, snap_p + 1);

    // Async reset while pressed drops the level immediately, no release pulse.
    snap_r = rel_cnt;
    @(negedge clk);
    btn_raw = 1'b1;
    #1;
    reset_n = 1'b0;
    #1;
    check("prsrst_level", btn_level, 0);
    edges(2);
    @(negedge clk);
    reset_n = 1'b1;
    edges(20);
    check("prsrst_no_release", rel_cnt, snap_r);
    check("prsrst_level_hold", btn_level, 0);

`ifdef BTN_STICKY_EN
    // 6: sticky flag
    clean_change("sticky_press", 1'b0, 1'b1);
    check("flag_set", press_flag, 1);
    edges(20);
    check("flag_held", press_flag, 1);
    @(negedge clk);
    flag_clr = 1'b1;
    edges(1);
    check("flag_lone_clr", press_flag, 0);
    @(negedge clk);
    flag_clr = 1'b0;
    clean_change("sticky_release", 1'b1, 1'b0);
    check("flag_still_clr", press_flag, 0);
    drive(1'b0);
    edges(7);
    check("flag_pre_press", btn_press, 1);
    flag_clr = 1'b1;
    edges(1);
    check("flag_set_wins", press_flag, 1);
    @(negedge clk);
    flag_clr = 1'b0;
    edges(5);
    check("flag_set_hold", press_flag, 1);
    @(negedge clk);
    flag_clr = 1'b1;
    edges(1);
    check("flag_clr2", press_flag, 0);
    @(negedge clk);
    flag_clr = 1'b0;
`endif

    check("never_both", both_cnt, 0);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
